// File: rtl/hash_table_pkg.sv
// Shared definitions for the hash table arbiter: packet geometry, field
// offsets, lock state encoding and a width helper.
package hash_table_pkg;

  // Result flags sit directly above the data field in a response packet.
  localparam int FLAG_OFS_0 = 0;
  localparam int FLAG_OFS_1 = 1;
  localparam int FLAG_OFS_2 = 2;
  localparam int FLAG_OFS_3 = 3;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int pkt_w(input int data_width, input int key_width);
    return 2 + data_width + key_width;
  endfunction

  function automatic int op_lsb(input int data_width, input int key_width);
    return data_width + key_width;
  endfunction

  function automatic int flag_bit(input int data_width, input int flag_ofs);
    return data_width + flag_ofs;
  endfunction

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/hash_table_arbiter_id_fifo.sv
// In-order FIFO of requester indices for requests in flight; a push while
// full or a pop while empty is ignored.
module id_fifo
  import hash_table_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_table_arbiter.sv
// Round-robin sharing of one hash table channel between NUM_REQ requesters,
// with in-order response routing through an ID FIFO.
//   state     | meaning
//   LOCK_IDLE | grant follows the round-robin search every cycle
//   LOCK_HELD | table stalled a valid request; grant frozen until handshake
module hash_table_arbiter
  import hash_table_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int KEY_WIDTH       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PKT_W = pkt_w(DATA_WIDTH, KEY_WIDTH),
  localparam int IDX_W = clog2(NUM_REQ),
  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*PKT_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [PKT_W-1:0]         rsp_data_o,
  output logic                     tbl_valid_o,
  input  logic                     tbl_ready_i,
  output logic [PKT_W-1:0]         tbl_data_o,
  input  logic                     tbl_valid_i,
  output logic                     tbl_ready_o,
  input  logic [PKT_W-1:0]         tbl_data_i,
  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     err_unexpected_rsp_o
);

  logic [PKT_W-1:0] req_pkt [NUM_REQ];
  lock_state_e      lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_grant;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] head;
  logic             rr_found;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_pkt[g] = req_data_i[g*PKT_W +: PKT_W];
  end

  // Descending scan so the closest valid requester at or after rr_q wins.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = rr_q;
    cand     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_q) + off) % NUM_REQ);
      if (req_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_grant = cand;
      end
    end
  end

  always_comb begin
    grant       = (lock_q == LOCK_HELD) ? lock_idx_q : rr_grant;
    tbl_valid_o = 1'b0;
    req_ready_o = '0;
    lock_d      = lock_q;
    if (reset && !fifo_full) begin
      tbl_valid_o = (lock_q == LOCK_HELD) ? req_valid_i[grant] : rr_found;
      if (tbl_valid_o) begin
        req_ready_o[grant] = tbl_ready_i;
      end
    end
    push = tbl_valid_o & tbl_ready_i;
    case (lock_q)
      LOCK_IDLE: if (tbl_valid_o && !tbl_ready_i) lock_d = LOCK_HELD;
      LOCK_HELD: if (push) lock_d = LOCK_IDLE;
      default:   lock_d = LOCK_IDLE;
    endcase
  end

  assign tbl_data_o = req_pkt[grant];
  assign rsp_data_o = tbl_data_i;

  // With nothing in flight the table is always accepted so strays drain.
  always_comb begin
    rsp_valid_o = '0;
    tbl_ready_o = 1'b0;
    pop         = 1'b0;
    if (reset) begin
      if (!fifo_empty) begin
        rsp_valid_o[head] = tbl_valid_i;
        tbl_ready_o       = rsp_ready_i[head];
        pop               = tbl_valid_i & rsp_ready_i[head];
      end else begin
        tbl_ready_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q               <= LOCK_IDLE;
      lock_idx_q           <= '0;
      rr_q                 <= '0;
      err_unexpected_rsp_o <= 1'b0;
    end else begin
      lock_q <= lock_d;
      if (lock_q == LOCK_IDLE && lock_d == LOCK_HELD) begin
        lock_idx_q <= grant;
      end
      if (push) begin
        rr_q <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      if (fifo_empty && tbl_valid_i) begin
        err_unexpected_rsp_o <= 1'b1;
      end
    end
  end

  id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (grant),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Bench for hash_table_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked each cycle against a queue model.
module tb_hash_table_arbiter;

  localparam int N  = 4;
  localparam int KW = 2;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int PW = 2 + DW + KW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*PW-1:0] req_data_i = '0;
  logic [N-1:0]    rsp_valid_o;
  logic [N-1:0]    rsp_ready_i = '0;
  logic [PW-1:0]   rsp_data_o;
  logic            tbl_valid_o;
  logic            tbl_ready_i = 1'b0;
  logic [PW-1:0]   tbl_data_o;
  logic            tbl_valid_i = 1'b0;
  logic            tbl_ready_o;
  logic [PW-1:0]   tbl_data_i = '0;
  logic [2:0]      outstanding_o;
  logic            err_unexpected_rsp_o;

  int n_vec = 0;
  int n_err = 0;

  hash_table_arbiter #(
    .NUM_REQ(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .tbl_valid_o(tbl_valid_o), .tbl_ready_i(tbl_ready_i), .tbl_data_o(tbl_data_o),
    .tbl_valid_i(tbl_valid_i), .tbl_ready_o(tbl_ready_o), .tbl_data_i(tbl_data_i),
    .outstanding_o(outstanding_o), .err_unexpected_rsp_o(err_unexpected_rsp_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [PW-1:0] pkt_of(input logic [N*PW-1:0] v, input int i);
    logic [N*PW-1:0] t;
    t = v >> (i * PW);
    return t[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_pkt();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[PW-1:0];
  endfunction

  // Reference model: issued requester ids in order, rr start, held grant.
  int m_ids[$];
  int m_rr   = 0;
  int m_lock = -1;
  bit m_err  = 0;

  always @(negedge clk) begin
    int g;
    bit found;
    logic exp_tv;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    logic e_tr;
    if (!reset) begin
      m_ids.delete();
      m_rr   = 0;
      m_lock = -1;
      m_err  = 0;
    end else begin
      found = 0;
      g = 0;
      if (m_lock >= 0) begin
        found = 1;
        g = m_lock;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!found && bit_of(req_valid_i, (m_rr + k) % N)) begin
            found = 1;
            g = (m_rr + k) % N;
          end
        end
      end
      exp_tv = (m_ids.size() < MO) && found && bit_of(req_valid_i, g);
      e_rdy  = (exp_tv && tbl_ready_i) ? N'(1 << g) : '0;
      if (m_ids.size() > 0) begin
        e_rv = tbl_valid_i ? N'(1 << m_ids[0]) : '0;
        e_tr = bit_of(rsp_ready_i, m_ids[0]);
      end else begin
        e_rv = '0;
        e_tr = 1'b1;
      end
      check("m_tbl_valid", 64'(tbl_valid_o), 64'(exp_tv));
      check("m_req_ready", 64'(req_ready_o), 64'(e_rdy));
      if (exp_tv) check("m_tbl_data", 64'(tbl_data_o), 64'(pkt_of(req_data_i, g)));
      check("m_rsp_valid", 64'(rsp_valid_o), 64'(e_rv));
      check("m_tbl_ready", 64'(tbl_ready_o), 64'(e_tr));
      if (tbl_valid_i) check("m_rsp_data", 64'(rsp_data_o), 64'(tbl_data_i));
      check("m_outstanding", 64'(outstanding_o), 64'(m_ids.size()));
      check("m_err", 64'(err_unexpected_rsp_o), 64'(m_err));
      if (tbl_valid_i && m_ids.size() == 0) m_err = 1;
      if (tbl_valid_i && e_tr && m_ids.size() > 0) void'(m_ids.pop_front());
      if (exp_tv && tbl_ready_i) begin
        m_ids.push_back(g);
        m_rr   = (g + 1) % N;
        m_lock = -1;
      end else if (exp_tv) begin
        m_lock = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = '0;
    tbl_ready_i = 1'b0;
    tbl_valid_i = 1'b0;
    rsp_ready_i = '0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_err", 64'(err_unexpected_rsp_o), 64'd0);
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid_i = '0;
    rsp_ready_i = '1;
    forever begin
      tick();
      tbl_valid_i = (outstanding_o != 0);
      tbl_data_i  = rand_pkt();
      if (!tbl_valid_i || n >= 20) break;
      n++;
    end
    @(negedge clk);
    check("drain_empty", 64'(outstanding_o), 64'd0);
  endtask

  initial begin
    logic [PW-1:0] p2, r1;
    logic [N-1:0] hs_req;
    bit tbl_acc, rsp_hs;
    int tq;

    // Reset values while reset is held, then idle after release.
    @(negedge clk);
    check("rst_tbl_valid", 64'(tbl_valid_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_tbl_ready", 64'(tbl_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("idle_tbl_ready", 64'(tbl_ready_o), 64'd1);

    // Requester 2 stalled three cycles by the table.
    p2 = 36'h9_1234_5678;
    tick();
    req_valid_i = 4'b0100;
    req_data_i[2*PW +: PW] = p2;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("lock_valid", 64'(tbl_valid_o), 64'd1);
      check("lock_ready", 64'(req_ready_o), 64'd0);
      check("lock_data", 64'(tbl_data_o), 64'(p2));
    end
    tick();
    tbl_ready_i = 1'b1;
    @(negedge clk);
    check("lock_hs_ready", 64'(req_ready_o), 64'b0100);
    tick();
    req_valid_i = '0;
    @(negedge clk);
    check("one_outstanding", 64'(outstanding_o), 64'd1);
    r1 = 36'hA_5A5A_0F0F;
    tick();
    tbl_valid_i = 1'b1;
    tbl_data_i  = r1;
    rsp_ready_i = '1;
    @(negedge clk);
    check("rsp2_valid", 64'(rsp_valid_o), 64'b0100);
    check("rsp2_data", 64'(rsp_data_o), 64'(r1));
    tick();
    tbl_valid_i = 1'b0;
    @(negedge clk);
    check("rsp2_drained", 64'(outstanding_o), 64'd0);

    // All requesters valid: grants 0,1,2,3,0,1, responses follow in order.
    do_reset();
    tbl_ready_i = 1'b1;
    rsp_ready_i = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      req_valid_i = '1;
      tbl_valid_i = (k >= 1);
      @(negedge clk);
      check("rr_grant", 64'(req_ready_o), 64'(1 << (k % 4)));
      if (k >= 1) check("rr_rsp", 64'(rsp_valid_o), 64'(1 << ((k - 1) % 4)));
    end
    tick();
    req_valid_i = '0;
    tbl_valid_i = 1'b1;
    @(negedge clk);
    check("rr_rsp_last", 64'(rsp_valid_o), 64'b0010);
    tick();
    tbl_valid_i = 1'b0;
    @(negedge clk);
    check("rr_empty", 64'(outstanding_o), 64'd0);

    // Fill the FIFO; a pop while full does not admit a push that cycle.
    tick();
    req_valid_i = '1;
    tbl_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      check("fill_grant", 64'(req_ready_o), 64'(1 << ((2 + k) % 4)));
    end
    tick();
    @(negedge clk);
    check("full_tbl_valid", 64'(tbl_valid_o), 64'd0);
    check("full_req_ready", 64'(req_ready_o), 64'd0);
    check("full_count", 64'(outstanding_o), 64'd4);
    tick();
    tbl_valid_i = 1'b1;
    @(negedge clk);
    check("full_pop_no_push", 64'(tbl_valid_o), 64'd0);
    check("full_pop_head", 64'(rsp_valid_o), 64'b0100);
    tick();
    tbl_valid_i = 1'b0;
    @(negedge clk);
    check("refill_valid", 64'(tbl_valid_o), 64'd1);
    check("refill_grant", 64'(req_ready_o), 64'b0100);
    check("refill_count", 64'(outstanding_o), 64'd3);
    tick();
    @(negedge clk);
    check("refull_valid", 64'(tbl_valid_o), 64'd0);
    drain();

    // Response to requester 1 back-pressured for five cycles.
    do_reset();
    tick();
    req_valid_i = 4'b0010;
    tbl_ready_i = 1'b1;
    @(negedge clk);
    check("bp_issue", 64'(req_ready_o), 64'b0010);
    tick();
    req_valid_i = 4'b1101;
    tbl_valid_i = 1'b1;
    tbl_data_i  = r1;
    rsp_ready_i = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      check("bp_tbl_ready", 64'(tbl_ready_o), 64'd0);
      check("bp_rsp_valid", 64'(rsp_valid_o), 64'b0010);
      check("bp_rsp_data", 64'(rsp_data_o), 64'(r1));
      check("bp_count", 64'(outstanding_o), 64'((c + 1 > 4) ? 4 : c + 1));
    end
    check("bp_full_blocks", 64'(tbl_valid_o), 64'd0);
    tick();
    req_valid_i = '0;
    rsp_ready_i = '1;
    @(negedge clk);
    check("bp_release", 64'(tbl_ready_o), 64'd1);
    tick();
    tbl_valid_i = 1'b0;
    drain();

    // Stray response with nothing in flight.
    tick();
    tbl_valid_i = 1'b1;
    @(negedge clk);
    check("stray_ready", 64'(tbl_ready_o), 64'd1);
    check("stray_rsp_valid", 64'(rsp_valid_o), 64'd0);
    tick();
    tbl_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stray_err_sticky", 64'(err_unexpected_rsp_o), 64'd1);
      tick();
    end

    // Async reset with three in flight and a locked grant.
    do_reset();
    tick();
    req_valid_i = '1;
    tbl_ready_i = 1'b1;
    tick();
    tick();
    tick();
    req_valid_i = 4'b1000;
    tbl_ready_i = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(tbl_valid_o), 64'd1);
    check("pre_rst_count", 64'(outstanding_o), 64'd3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_tbl_valid", 64'(tbl_valid_o), 64'd0);
    check("async_req_ready", 64'(req_ready_o), 64'd0);
    check("async_count", 64'(outstanding_o), 64'd0);
    check("async_tbl_ready", 64'(tbl_ready_o), 64'd0);
    check("async_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    req_valid_i = '1;
    tbl_ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready_o), 64'b0001);
    tick();
    req_valid_i = '0;
    drain();

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    hs_req = '0;
    tbl_acc = 0;
    rsp_hs = 0;
    tq = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!bit_of(req_valid_i, i) || bit_of(hs_req, i)) begin
          req_valid_i[i] = (($urandom % 3) == 0);
          req_data_i[i*PW +: PW] = rand_pkt();
        end
      end
      if (tbl_acc) tq++;
      if (rsp_hs) tq--;
      if (!tbl_valid_i || rsp_hs) begin
        tbl_valid_i = (tq > 0) && (($urandom % 2) == 0);
        tbl_data_i  = rand_pkt();
      end
      tbl_ready_i = (($urandom % 4) != 0);
      rsp_ready_i = N'($urandom);
      @(negedge clk);
      hs_req  = req_valid_i & req_ready_o;
      tbl_acc = tbl_valid_o & tbl_ready_i;
      rsp_hs  = tbl_valid_i & tbl_ready_o;
    end
    tick();
    idle_inputs();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
